capp_controller: RTL and testbench

CAPP_CONTROLLER -- requirements
Module: capp_controller

---
 rtl/capp_controller_if.sv | 27 ++
 rtl/capp_controller.sv | 147 ++++++++++++++
 tb/tb_capp_controller.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capp_controller_if.sv
// Command/response bus between a host and the CAPP controller.
// Handshake rule for both channels: a transfer happens on a rising CLK edge
// where valid and ready are both high. Once valid is raised, the sender holds
// valid and its payload unchanged until that edge. Ready may change freely.
interface capp_controller_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_data;
   logic [31:0] cmd_mask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_hit;
   logic [6:0]  rsp_index;
   logic [6:0]  rsp_count;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_mask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_index, rsp_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_mask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_index, rsp_count
   );
endinterface

// File: rtl/capp_controller.sv
// Controller for a 100-word x 32-bit content-addressable parallel processor.
// One command at a time: accept, drive the cell array for one cycle, update
// the tag register, summarise the tags and hold a response until taken.
module capp_controller (
   input  logic                    CLK,
   input  logic                    RST,
   capp_controller_if.slave        bus,
   output logic [63:0]             mismatch_lines,
   output logic [63:0]             write_lines,
   output logic [99:0]             tags,
   input  logic [99:0]             match_lines,
   input  logic [31:0]             read_lines,
   output logic [2:0]              state_o
);

   localparam logic [2:0] OP_TAG_ALL      = 3'd0;
   localparam logic [2:0] OP_SEARCH       = 3'd1;
   localparam logic [2:0] OP_SEARCH_AND   = 3'd2;
   localparam logic [2:0] OP_SELECT_FIRST = 3'd3;
   localparam logic [2:0] OP_WRITE        = 3'd4;
   localparam logic [2:0] OP_READ         = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EXEC   = 3'd1,
      S_SETTLE = 3'd2,
      S_EVAL   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t      state_q;
   logic [2:0]  op_q;
   logic [63:0] mismatch_lines_q;
   logic [63:0] write_lines_q;
   logic [99:0] tags_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_data_q;
   logic        rsp_hit_q;
   logic [6:0]  rsp_index_q;
   logic [6:0]  rsp_count_q;

   logic [6:0]  tag_count;
   logic [6:0]  tag_index;
   logic        tag_found;

   // Dual-rail encoding of key bits: pair j is {~d, d} when enabled, 00 when
   // masked. The two rails of a pair are complementary, so 11 cannot occur.
   function automatic logic [63:0] encode_lines(input logic [31:0] d,
                                                input logic [31:0] m);
      logic [63:0] l;
      l = '0;
      for (int j = 0; j < 32; j++) begin
         l[2*j]   = d[j] & m[j];
         l[2*j+1] = ~d[j] & m[j];
      end
      return l;
   endfunction

   // Tag summary: number of tagged words and the lowest tagged index.
   always_comb begin
      tag_count = '0;
      tag_index = '0;
      tag_found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tag_count = tag_count + 7'(tags_q[i]);
         if (tags_q[i] && !tag_found) begin
            tag_index = 7'(i);
            tag_found = 1'b1;
         end
      end
   end

   // Command sequencer with all outputs registered; reset aborts any command.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q          <= S_IDLE;
         op_q             <= '0;
         mismatch_lines_q <= '0;
         write_lines_q    <= '0;
         tags_q           <= '0;
         rsp_valid_q      <= 1'b0;
         rsp_data_q       <= '0;
         rsp_hit_q        <= 1'b0;
         rsp_index_q      <= '0;
         rsp_count_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  op_q    <= bus.cmd_op;
                  state_q <= S_EXEC;
                  if (bus.cmd_op == OP_SEARCH || bus.cmd_op == OP_SEARCH_AND)
                     mismatch_lines_q <= encode_lines(bus.cmd_data, bus.cmd_mask);
                  if (bus.cmd_op == OP_WRITE)
                     write_lines_q <= encode_lines(bus.cmd_data, bus.cmd_mask);
               end
            end
            S_EXEC: begin
               mismatch_lines_q <= '0;
               write_lines_q    <= '0;
               rsp_data_q       <= '0;
               case (op_q)
                  OP_TAG_ALL:      tags_q     <= '1;
                  OP_SEARCH:       tags_q     <= ~match_lines;
                  OP_SEARCH_AND:   tags_q     <= tags_q & ~match_lines;
                  OP_SELECT_FIRST: tags_q     <= tags_q & (~tags_q + 100'd1);
                  OP_READ:         rsp_data_q <= read_lines;
                  default: ;
               endcase
               // The cell store commits writes two edges after the drive.
               state_q <= (op_q == OP_WRITE) ? S_SETTLE : S_EVAL;
            end
            S_SETTLE: begin
               state_q <= S_EVAL;
            end
            S_EVAL: begin
               rsp_hit_q   <= |tags_q;
               rsp_count_q <= tag_count;
               rsp_index_q <= tag_index;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Ready is gated by RST directly so it drops the instant reset is applied
   // and rises on the first cycle after release.
   assign bus.cmd_ready  = (state_q == S_IDLE) && !RST;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_hit    = rsp_hit_q;
   assign bus.rsp_index  = rsp_index_q;
   assign bus.rsp_count  = rsp_count_q;
   assign mismatch_lines = mismatch_lines_q;
   assign write_lines    = write_lines_q;
   assign tags           = tags_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_capp_controller.sv
// Bench for capp_controller: a behavioural cell array answers the line
// drives, and a word-level reference model predicts every response.
module tb_capp_controller;

   logic        CLK;
   logic        RST;
   logic [63:0] mismatch_lines;
   logic [63:0] write_lines;
   logic [99:0] tags;
   logic [99:0] match_lines;
   logic [31:0] read_lines;
   logic [2:0]  state_o;

   capp_controller_if bus();

   capp_controller dut (
      .CLK            (CLK),
      .RST            (RST),
      .bus            (bus),
      .mismatch_lines (mismatch_lines),
      .write_lines    (write_lines),
      .tags           (tags),
      .match_lines    (match_lines),
      .read_lines     (read_lines),
      .state_o        (state_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- cell array environment ----------------
   logic [31:0] words      [100];
   logic [31:0] init_words [100];
   logic        load_words;

   always_comb begin
      for (int i = 0; i < 100; i++) begin
         match_lines[i] = 1'b0;
         for (int j = 0; j < 32; j++)
            if ((mismatch_lines[2*j] && !words[i][j]) ||
                (mismatch_lines[2*j+1] && words[i][j]))
               match_lines[i] = 1'b1;
      end
   end

   always_comb begin
      read_lines = '0;
      for (int i = 0; i < 100; i++)
         if (tags[i]) read_lines = read_lines | words[i];
   end

   always @(posedge CLK) begin
      if (load_words) begin
         for (int i = 0; i < 100; i++) words[i] <= init_words[i];
      end else begin
         for (int i = 0; i < 100; i++)
            if (tags[i])
               for (int j = 0; j < 32; j++) begin
                  if (write_lines[2*j])        words[i][j] <= 1'b1;
                  else if (write_lines[2*j+1]) words[i][j] <= 1'b0;
               end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_words [100];
   logic [99:0] exp_tags;

   function automatic logic [99:0] model_search(input logic [31:0] key,
                                                input logic [31:0] mask);
      logic [99:0] t;
      for (int i = 0; i < 100; i++)
         t[i] = (((exp_words[i] ^ key) & mask) == 32'd0);
      return t;
   endfunction

   function automatic logic [6:0] model_index(input logic [99:0] t);
      for (int i = 0; i < 100; i++)
         if (t[i]) return 7'(i);
      return 7'd0;
   endfunction

   function automatic logic [99:0] model_first(input logic [99:0] t);
      logic [99:0] r;
      r = '0;
      for (int i = 0; i < 100; i++)
         if (t[i]) begin
            r[i] = 1'b1;
            return r;
         end
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [99:0] t);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 100; i++)
         if (t[i]) r = r | exp_words[i];
      return r;
   endfunction

   // Advance the model by one command; returns expected data and latency.
   task automatic model_apply(input logic [2:0] op, input logic [31:0] d,
                              input logic [31:0] m,
                              output logic [31:0] e_rd, output int e_lat);
      e_rd  = '0;
      e_lat = 2;
      case (op)
         3'd0: exp_tags = '1;
         3'd1: exp_tags = model_search(d, m);
         3'd2: exp_tags = exp_tags & model_search(d, m);
         3'd3: exp_tags = model_first(exp_tags);
         3'd4: begin
            e_lat = 3;
            for (int i = 0; i < 100; i++)
               if (exp_tags[i]) exp_words[i] = (exp_words[i] & ~m) | (d & m);
         end
         3'd5: e_rd = model_read(exp_tags);
         default: ;
      endcase
   endtask

   // ---------------- driver ----------------
   task automatic run_cmd(input logic [2:0] op, input logic [31:0] d,
                          input logic [31:0] m, input int delay,
                          output logic [31:0] rd, output logic hit,
                          output logic [6:0] idx, output logic [6:0] cnt,
                          output int lat, output logic [63:0] ml,
                          output logic [63:0] wl, output int unstable,
                          output int cr_busy, output logic rv_after);
      int w;
      lat = -1; unstable = 0; cr_busy = 0; rv_after = 1'b0;
      rd = '0; hit = 1'b0; idx = '0; cnt = '0;
      w = 0;
      @(negedge CLK);
      while (!bus.cmd_ready && w < 20) begin
         @(negedge CLK);
         w++;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_mask  = m;
      @(posedge CLK); #1;
      ml = mismatch_lines;
      wl = write_lines;
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge CLK); #1;
         if (bus.rsp_valid) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) return;
      rd = bus.rsp_data; hit = bus.rsp_hit; idx = bus.rsp_index; cnt = bus.rsp_count;
      for (int k = 0; k < delay; k++) begin
         @(posedge CLK); #1;
         if (!bus.rsp_valid || bus.rsp_data !== rd || bus.rsp_hit !== hit ||
             bus.rsp_index !== idx || bus.rsp_count !== cnt)
            unstable++;
         if (bus.cmd_ready) cr_busy++;
      end
      bus.rsp_ready = 1'b1;
      @(posedge CLK); #1;
      bus.rsp_ready = 1'b0;
      rv_after = bus.rsp_valid;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      load_words = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_data = '0; bus.cmd_mask = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 100; i++) begin
         init_words[i] = $urandom;
         if (init_words[i] == 32'd5) init_words[i] = 32'd6;
      end
      init_words[5]  = 32'd5;
      init_words[37] = 32'd5;
      for (int i = 0; i < 100; i++) exp_words[i] = init_words[i];
      exp_tags = '0;
      repeat (2) @(posedge CLK);
      #1;
      load_words = 1'b0;
      n_tests++;
      if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || tags !== '0 ||
          mismatch_lines !== '0 || write_lines !== '0 || state_o !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b valid=%b tags=%h ml=%h wl=%h state=%0d, want all 0",
                  bus.cmd_ready, bus.rsp_valid, tags, mismatch_lines, write_lines, state_o);
      end
      n_tests++;
      if (bus.rsp_data !== '0 || bus.rsp_hit !== 1'b0 || bus.rsp_index !== '0 ||
          bus.rsp_count !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp: data=%h hit=%b idx=%0d cnt=%0d, want 0",
                  bus.rsp_data, bus.rsp_hit, bus.rsp_index, bus.rsp_count);
      end
      @(negedge CLK);
      RST = 1'b0;
      #1;
      n_tests++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
      end
   endtask

   task automatic test_tag_all();
      logic [31:0] rd, e_rd; logic hit; logic [6:0] idx, cnt; int lat, e_lat;
      logic [63:0] ml, wl; int uns, crb; logic rva;
      logic [31:0] d, m;
      d = $urandom; m = $urandom;
      run_cmd(3'd0, d, m, 0, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd0, d, m, e_rd, e_lat);
      n_tests++;
      if (lat !== e_lat) begin
         n_fail++; $display("FAIL tag_all_latency: got %0d want %0d", lat, e_lat);
      end
      n_tests++;
      if (hit !== 1'b1 || cnt !== 7'd100 || idx !== 7'd0 || rd !== 32'd0) begin
         n_fail++;
         $display("FAIL tag_all_rsp: hit=%b cnt=%0d idx=%0d data=%h want 1/100/0/0", hit, cnt, idx, rd);
      end
      n_tests++;
      if (tags !== exp_tags || ml !== '0 || wl !== '0 || rva !== 1'b0) begin
         n_fail++;
         $display("FAIL tag_all_state: tags=%h ml=%h wl=%h rv_after=%b", tags, ml, wl, rva);
      end
   endtask

   task automatic test_search();
      logic [31:0] rd, e_rd; logic hit; logic [6:0] idx, cnt; int lat, e_lat;
      logic [63:0] ml, wl; int uns, crb; logic rva;
      logic [99:0] want;
      run_cmd(3'd1, 32'h5, 32'hFFFFFFFF, 0, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd1, 32'h5, 32'hFFFFFFFF, e_rd, e_lat);
      want = '0; want[5] = 1'b1; want[37] = 1'b1;
      n_tests++;
      if (ml !== 64'hAAAAAAAAAAAAAA99) begin
         n_fail++; $display("FAIL search_lines: got %h want aaaaaaaaaaaaaa99", ml);
      end
      n_tests++;
      if (tags !== want || tags !== exp_tags) begin
         n_fail++; $display("FAIL search_tags: got %h want %h", tags, want);
      end
      n_tests++;
      if (cnt !== 7'd2 || idx !== 7'd5 || hit !== 1'b1 || lat !== e_lat || wl !== '0) begin
         n_fail++;
         $display("FAIL search_rsp: cnt=%0d idx=%0d hit=%b lat=%0d wl=%h want 2/5/1/%0d/0",
                  cnt, idx, hit, lat, wl, e_lat);
      end
   endtask

   task automatic test_select_first();
      logic [31:0] rd, e_rd; logic hit; logic [6:0] idx, cnt; int lat, e_lat;
      logic [63:0] ml, wl; int uns, crb; logic rva;
      logic [99:0] want;
      run_cmd(3'd3, $urandom, $urandom, 1, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd3, 32'd0, 32'd0, e_rd, e_lat);
      want = '0; want[5] = 1'b1;
      n_tests++;
      if (tags !== want || tags !== exp_tags) begin
         n_fail++; $display("FAIL select_first_tags: got %h want %h", tags, want);
      end
      n_tests++;
      if (cnt !== 7'd1 || idx !== 7'd5 || hit !== 1'b1 || lat !== e_lat || ml !== '0) begin
         n_fail++;
         $display("FAIL select_first_rsp: cnt=%0d idx=%0d hit=%b lat=%0d ml=%h want 1/5/1/2/0",
                  cnt, idx, hit, lat, ml);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd, e_rd; logic hit; logic [6:0] idx, cnt; int lat, e_lat;
      logic [63:0] ml, wl; int uns, crb; logic rva;
      logic [99:0] tags_before;
      tags_before = exp_tags;
      run_cmd(3'd4, 32'hDEADBEEF, 32'hFFFF0000, $urandom_range(0, 2),
              rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd4, 32'hDEADBEEF, 32'hFFFF0000, e_rd, e_lat);
      n_tests++;
      if (wl[31:0] !== 32'd0 || (wl & (wl >> 1) & 64'h5555555555555555) !== '0 || wl === '0) begin
         n_fail++; $display("FAIL write_lines: got %h want low half 0, no 11 pair, nonzero", wl);
      end
      n_tests++;
      if (lat !== 3 || tags !== tags_before || rd !== 32'd0 || cnt !== 7'd1 || idx !== 7'd5) begin
         n_fail++;
         $display("FAIL write_rsp: lat=%0d tags=%h data=%h cnt=%0d idx=%0d want 3/%h/0/1/5",
                  lat, tags, rd, cnt, idx, tags_before);
      end
      run_cmd(3'd5, $urandom, $urandom, 0, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd5, 32'd0, 32'd0, e_rd, e_lat);
      n_tests++;
      if (rd !== e_rd || rd[31:16] !== 16'hDEAD || lat !== e_lat) begin
         n_fail++; $display("FAIL read_data: got %h lat=%0d want %h lat=%0d", rd, lat, e_rd, e_lat);
      end
   endtask

   task automatic test_select_empty();
      logic [31:0] rd, e_rd; logic hit; logic [6:0] idx, cnt; int lat, e_lat;
      logic [63:0] ml, wl; int uns, crb; logic rva;
      logic [31:0] key;
      key = $urandom;
      while (model_search(key, 32'hFFFFFFFF) !== '0) key = $urandom;
      run_cmd(3'd1, key, 32'hFFFFFFFF, 0, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd1, key, 32'hFFFFFFFF, e_rd, e_lat);
      n_tests++;
      if (hit !== 1'b0 || cnt !== 7'd0 || tags !== '0) begin
         n_fail++; $display("FAIL search_none: hit=%b cnt=%0d tags=%h want 0", hit, cnt, tags);
      end
      run_cmd(3'd3, $urandom, $urandom, 0, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd3, 32'd0, 32'd0, e_rd, e_lat);
      n_tests++;
      if (hit !== 1'b0 || cnt !== 7'd0 || idx !== 7'd0 || tags !== '0 || lat !== e_lat) begin
         n_fail++;
         $display("FAIL select_first_empty: hit=%b cnt=%0d idx=%0d tags=%h lat=%0d want 0/0/0/0/2",
                  hit, cnt, idx, tags, lat);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, e_rd; logic hit; logic [6:0] idx, cnt; int lat, e_lat;
      logic [63:0] ml, wl; int uns, crb; logic rva;
      run_cmd(3'd0, 32'd0, 32'd0, 0, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd0, 32'd0, 32'd0, e_rd, e_lat);
      run_cmd(3'd2, exp_words[17], 32'h000000FF, 5, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd2, exp_words[17], 32'h000000FF, e_rd, e_lat);
      n_tests++;
      if (uns !== 0 || crb !== 0) begin
         n_fail++; $display("FAIL backpressure_hold: unstable=%0d ready_high=%0d want 0/0", uns, crb);
      end
      n_tests++;
      if (rva !== 1'b0 || state_o !== 3'd0) begin
         n_fail++; $display("FAIL backpressure_release: rsp_valid=%b state=%0d want 0/0", rva, state_o);
      end
      n_tests++;
      if (hit !== (|exp_tags) || cnt !== 7'($countones(exp_tags)) || idx !== model_index(exp_tags)) begin
         n_fail++;
         $display("FAIL search_and_rsp: hit=%b cnt=%0d idx=%0d want %b/%0d/%0d",
                  hit, cnt, idx, |exp_tags, $countones(exp_tags), model_index(exp_tags));
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, e_rd; logic hit; logic [6:0] idx, cnt; int lat, e_lat;
      logic [63:0] ml, wl; int uns, crb; logic rva;
      int bad_words, rv_seen;
      run_cmd(3'd0, 32'd0, 32'd0, 0, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd0, 32'd0, 32'd0, e_rd, e_lat);
      @(negedge CLK);
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4;
      bus.cmd_data = $urandom; bus.cmd_mask = 32'hFFFFFFFF;
      @(posedge CLK); #1;
      bus.cmd_valid = 1'b0;
      n_tests++;
      if (write_lines === '0 || state_o !== 3'd1) begin
         n_fail++; $display("FAIL write_exec_drive: wl=%h state=%0d want nonzero/1", write_lines, state_o);
      end
      RST = 1'b1;
      #1;
      n_tests++;
      if (write_lines !== '0 || tags !== '0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_immediate: wl=%h tags=%h valid=%b ready=%b want 0",
                  write_lines, tags, bus.rsp_valid, bus.cmd_ready);
      end
      exp_tags = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      n_tests++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_ready: got %b want 1", bus.cmd_ready);
      end
      rv_seen = 0;
      repeat (4) begin
         @(posedge CLK); #1;
         if (bus.rsp_valid || write_lines !== '0) rv_seen++;
      end
      bad_words = 0;
      for (int i = 0; i < 100; i++) if (words[i] !== exp_words[i]) bad_words++;
      n_tests++;
      if (rv_seen !== 0 || bad_words !== 0) begin
         n_fail++; $display("FAIL reset_mid_abort: activity=%0d changed_words=%0d want 0/0", rv_seen, bad_words);
      end
      run_cmd(3'd0, 32'd0, 32'd0, 0, rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
      model_apply(3'd0, 32'd0, 32'd0, e_rd, e_lat);
      n_tests++;
      if (lat !== 2 || cnt !== 7'd100 || hit !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_reaccept: lat=%0d cnt=%0d hit=%b want 2/100/1", lat, cnt, hit);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, e_rd; logic hit; logic [6:0] idx, cnt; int lat, e_lat;
      logic [63:0] ml, wl; int uns, crb; logic rva;
      logic [2:0] op; logic [31:0] d, m;
      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 7));
         m  = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
         d  = ($urandom_range(0, 1) == 1) ? exp_words[$urandom_range(0, 99)] : $urandom;
         run_cmd(op, d, m, $urandom_range(0, 3), rd, hit, idx, cnt, lat, ml, wl, uns, crb, rva);
         model_apply(op, d, m, e_rd, e_lat);
         n_tests++;
         if (lat !== e_lat || rd !== e_rd || hit !== (|exp_tags) ||
             cnt !== 7'($countones(exp_tags)) || idx !== model_index(exp_tags) ||
             tags !== exp_tags || uns !== 0 || rva !== 1'b0) begin
            n_fail++;
            $display("FAIL random_%0d op=%0d: lat=%0d data=%h hit=%b cnt=%0d idx=%0d want lat=%0d data=%h hit=%b cnt=%0d idx=%0d",
                     n, op, lat, rd, hit, cnt, idx, e_lat, e_rd, |exp_tags,
                     $countones(exp_tags), model_index(exp_tags));
         end
      end
   endtask

   initial begin
      test_reset();
      test_tag_all();
      test_search();
      test_select_first();
      test_write_read();
      test_select_empty();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
